// File: rtl/tape_ram_writer_if.sv
// Bus bundle for the tape RAM writer: loader byte stream, CPU RAM request
// and the merged RAM write port.
interface tape_ram_writer_if #(
  parameter int AW = 16
) ();
  logic [AW-1:0] tape_addr;
  logic          tape_wr;
  logic [7:0]    tape_dout;
  logic          cpu_ram_cs;
  logic          cpu_ram_we;
  logic [AW-1:0] cpu_ad;
  logic [7:0]    cpu_d;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_ad;
  logic [7:0]    ram_d;

  modport master (
    output tape_addr, tape_wr, tape_dout, cpu_ram_cs, cpu_ram_we, cpu_ad, cpu_d,
    input  ram_cs, ram_we, ram_ad, ram_d
  );

  modport slave (
    input  tape_addr, tape_wr, tape_dout, cpu_ram_cs, cpu_ram_we, cpu_ad, cpu_d,
    output ram_cs, ram_we, ram_ad, ram_d
  );
endinterface

// File: rtl/tape_ram_writer.sv
// Merges the cassette loader byte stream into the shared RAM port behind the CPU,
// buffering tape bytes in a small FIFO and reporting the committed load range.
module tape_ram_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic            clk_48,
  input  logic            reset,
  tape_ram_writer_if.slave bus,
  input  logic            tape_complete,
  input  logic            tape_autorun,
  output logic            tape_stall,
  output logic            busy,
  output logic            overflow,
  output logic [AW-1:0]   load_start,
  output logic [AW-1:0]   load_end,
  output logic            load_done,
  output logic            load_autorun
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL     = (PW+1)'(DEPTH);
  localparam logic [PW:0] STALL_AT = (PW+1)'(DEPTH-2);

  typedef enum logic [1:0] {IDLE, LOADING, DRAIN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW+7:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [PW:0]     r_count, w_count_nxt;
  logic            r_cmpl_q, r_stall, r_ovf, r_autorun;
  logic [AW-1:0]   r_start, r_end;
  logic [AW+7:0]   w_head;
  logic            w_cmpl_rise, w_pop, w_push, w_drop;
  logic            w_start, w_arm;

  assign w_cmpl_rise = tape_complete & ~r_cmpl_q;
  assign w_head      = r_mem[r_rd_ptr];
  // No tape write may reach RAM while reset is asserted.
  assign w_pop       = ~reset & ~bus.cpu_ram_cs & (r_count != '0);
  assign w_push      = bus.tape_wr & ((r_count < FULL) | w_pop);
  assign w_drop      = bus.tape_wr & ~w_push;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PW+1)'(1);
      2'b01:   w_count_nxt = r_count - (PW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    bus.ram_cs = 1'b0;
    bus.ram_we = 1'b0;
    bus.ram_ad = bus.cpu_ad;
    bus.ram_d  = 8'h00;
    if (bus.cpu_ram_cs) begin
      bus.ram_cs = 1'b1;
      bus.ram_we = bus.cpu_ram_we;
      bus.ram_d  = bus.cpu_d;
    end else if (w_pop) begin
      bus.ram_cs = 1'b1;
      bus.ram_we = 1'b1;
      bus.ram_ad = w_head[AW+7:8];
      bus.ram_d  = w_head[7:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_arm       = 1'b0;
    case (r_state)
      IDLE: begin
        // An empty tape completes straight from IDLE with a fresh, empty range.
        if (w_cmpl_rise) begin
          w_state_nxt = DRAIN;
          w_start     = 1'b1;
          w_arm       = 1'b1;
        end else if (bus.tape_wr) begin
          w_state_nxt = LOADING;
          w_start     = 1'b1;
        end
      end
      LOADING: if (w_cmpl_rise) begin
        w_state_nxt = DRAIN;
        w_arm       = 1'b1;
      end
      DRAIN:   if (r_count == '0 && !bus.tape_wr) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_cmpl_q  <= 1'b0;
      r_stall   <= 1'b0;
      r_ovf     <= 1'b0;
      r_autorun <= 1'b0;
      r_start   <= '1;
      r_end     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_cmpl_q <= tape_complete;
      r_stall  <= (w_count_nxt >= STALL_AT);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_start)     r_ovf <= w_drop;
      else if (w_drop) r_ovf <= 1'b1;
      if (w_arm)        r_autorun <= tape_autorun;
      else if (w_start) r_autorun <= 1'b0;
      if (w_start) begin
        r_start <= w_push ? bus.tape_addr : '1;
        r_end   <= w_push ? bus.tape_addr : '0;
      end else if (w_push) begin
        if (bus.tape_addr < r_start) r_start <= bus.tape_addr;
        if (bus.tape_addr > r_end)   r_end   <= bus.tape_addr;
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.tape_addr, bus.tape_dout};
  end

  assign tape_stall   = r_stall;
  assign busy         = (r_state != IDLE) | (r_count != '0);
  assign overflow     = r_ovf;
  assign load_start   = r_start;
  assign load_end     = r_end;
  assign load_done    = (r_state == DONE);
  assign load_autorun = r_autorun;
endmodule

// File: tb/tb_tape_ram_writer.sv
// Directed bench for tape_ram_writer: tape RAM writes are checked against a
// scoreboard queue filled as bytes are driven; status outputs checked inline.
module tb_tape_ram_writer;
  logic        clk_48 = 1'b0;
  logic        reset;
  logic        tape_complete, tape_autorun;
  logic        tape_stall, busy, overflow, load_done, load_autorun;
  logic [15:0] load_start, load_end;
  logic [23:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_48 = ~clk_48;

  tape_ram_writer_if #(.AW(16)) bus_if ();

  tape_ram_writer #(.DEPTH(8), .AW(16)) dut (
    .clk_48(clk_48), .reset(reset), .bus(bus_if),
    .tape_complete(tape_complete), .tape_autorun(tape_autorun),
    .tape_stall(tape_stall), .busy(busy), .overflow(overflow),
    .load_start(load_start), .load_end(load_end),
    .load_done(load_done), .load_autorun(load_autorun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic drive_tape(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus_if.tape_wr   = wr;
    bus_if.tape_addr = a;
    bus_if.tape_dout = d;
  endtask

  // Any tape-sourced write (RAM written while the CPU is not selecting it)
  // must match the oldest expected byte; 0xFFFFFFFF flags an unexpected write.
  always @(negedge clk_48) begin
    if (bus_if.ram_cs === 1'b1 && bus_if.ram_we === 1'b1 && bus_if.cpu_ram_cs === 1'b0)
      chk("sb_wr", {8'h00, bus_if.ram_ad, bus_if.ram_d},
          (sb_q.size() != 0) ? {8'h00, sb_q.pop_front()} : 32'hFFFF_FFFF);
  end

  initial begin
    logic [15:0] addrs [3];
    int          cnt;
    reset = 1'b1;
    tape_complete = 1'b0;
    tape_autorun  = 1'b0;
    drive_tape(1'b0, 16'h0, 8'h0);
    bus_if.cpu_ram_cs = 1'b0;
    bus_if.cpu_ram_we = 1'b0;
    bus_if.cpu_ad     = 16'h0;
    bus_if.cpu_d      = 8'h0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_start", load_start, 16'hFFFF);
    chk("rst_end", load_end, 16'h0000);
    chk("rst_done", load_done, 1'b0);
    chk("rst_stall", tape_stall, 1'b0);
    chk("rst_autorun", load_autorun, 1'b0);
    chk("rst_ram_cs", bus_if.ram_cs, 1'b0);
    reset = 1'b0;

    // Streaming bytes with the CPU idle: one-cycle latency to the RAM port.
    for (int i = 0; i < 4; i++) begin
      drive_tape(i < 3, 16'h0500 + 16'(i), 8'h11 * 8'(i + 1));
      if (i < 3) sb_q.push_back({16'h0500 + 16'(i), 8'h11 * 8'(i + 1)});
      #1;
      if (i > 0) begin
        chk("t1_lat_ad", bus_if.ram_ad, 16'h0500 + 16'(i - 1));
        chk("t1_lat_d", bus_if.ram_d, 8'h11 * 8'(i));
        chk("t1_lat_we", bus_if.ram_we, 1'b1);
      end
      tick();
    end
    drive_tape(1'b0, 16'h0, 8'h0);
    #1;
    chk("t1_idle_cs", bus_if.ram_cs, 1'b0);
    chk("t1_start", load_start, 16'h0500);
    chk("t1_end", load_end, 16'h0502);
    chk("t1_busy", busy, 1'b1);

    // CPU owns RAM for 10 cycles while 8 bytes queue up, then they drain.
    for (int k = 0; k < 18; k++) begin
      bus_if.cpu_ram_cs = (k < 10);
      bus_if.cpu_ram_we = 1'b1;
      bus_if.cpu_ad     = 16'h1200 + 16'(k);
      bus_if.cpu_d      = 8'(k);
      drive_tape(k < 8, 16'h0600 + 16'(k), 8'hA0 + 8'(k));
      if (k < 8) sb_q.push_back({16'h0600 + 16'(k), 8'hA0 + 8'(k)});
      cnt = (k < 10) ? ((k < 8) ? k : 8) : 8 - (k - 10);
      #1;
      chk("t2_stall", tape_stall, cnt >= 6);
      if (k < 10) begin
        chk("t2_cpu_cs", bus_if.ram_cs, 1'b1);
        chk("t2_cpu_we", bus_if.ram_we, 1'b1);
        chk("t2_cpu_ad", bus_if.ram_ad, 16'h1200 + 16'(k));
        chk("t2_cpu_d", bus_if.ram_d, 8'(k));
      end
      tick();
    end
    bus_if.cpu_ram_cs = 1'b0;
    drive_tape(1'b0, 16'h0, 8'h0);
    #1;
    chk("t2_drained_cs", bus_if.ram_cs, 1'b0);
    chk("t2_sb_empty", sb_q.size(), 0);
    chk("t2_end", load_end, 16'h0607);

    // Nine bytes against a busy CPU: the ninth is dropped.
    for (int k = 0; k < 9; k++) begin
      bus_if.cpu_ram_cs = 1'b1;
      bus_if.cpu_ram_we = 1'b0;
      drive_tape(1'b1, 16'h0700 + 16'(k), 8'h70 + 8'(k));
      if (k < 8) sb_q.push_back({16'h0700 + 16'(k), 8'h70 + 8'(k)});
      tick();
    end
    drive_tape(1'b0, 16'h0, 8'h0);
    #1;
    chk("t3_ovf", overflow, 1'b1);
    bus_if.cpu_ram_cs = 1'b0;
    repeat (10) tick();
    chk("t3_sb_empty", sb_q.size(), 0);
    chk("t3_ovf_sticky", overflow, 1'b1);
    chk("t3_end", load_end, 16'h0707);

    // Completion with autorun and 3 bytes still buffered.
    for (int k = 0; k < 3; k++) begin
      bus_if.cpu_ram_cs = 1'b1;
      drive_tape(1'b1, 16'h0800 + 16'(k), 8'h80 + 8'(k));
      sb_q.push_back({16'h0800 + 16'(k), 8'h80 + 8'(k)});
      tick();
    end
    drive_tape(1'b0, 16'h0, 8'h0);
    bus_if.cpu_ram_cs = 1'b0;
    tape_complete = 1'b1;
    tape_autorun  = 1'b1;
    for (int off = 0; off < 12; off++) begin
      #1;
      chk("t4_done", load_done, off == 4);
      tick();
    end
    chk("t4_autorun", load_autorun, 1'b1);
    chk("t4_start", load_start, 16'h0500);
    chk("t4_end", load_end, 16'h0802);
    chk("t4_busy", busy, 1'b0);
    chk("t4_sb_empty", sb_q.size(), 0);
    tape_complete = 1'b0;
    tape_autorun  = 1'b0;
    tick();

    // Unordered addresses in a fresh load.
    addrs[0] = 16'h9800; addrs[1] = 16'h0400; addrs[2] = 16'hBFFF;
    for (int k = 0; k < 3; k++) begin
      drive_tape(1'b1, addrs[k], 8'hC0 + 8'(k));
      sb_q.push_back({addrs[k], 8'hC0 + 8'(k)});
      tick();
    end
    drive_tape(1'b0, 16'h0, 8'h0);
    tick(); tick();
    chk("t6_ovf_clr", overflow, 1'b0);
    chk("t6_start", load_start, 16'h0400);
    chk("t6_end", load_end, 16'hBFFF);
    chk("t6_sb_empty", sb_q.size(), 0);

    // Reset with 5 bytes buffered; none of them may reach RAM.
    for (int k = 0; k < 5; k++) begin
      bus_if.cpu_ram_cs = 1'b1;
      drive_tape(1'b1, 16'hC000 + 16'(k), 8'h50 + 8'(k));
      tick();
    end
    drive_tape(1'b0, 16'h0, 8'h0);
    bus_if.cpu_ram_cs = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_rst_we", bus_if.ram_we, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    chk("t5_end", load_end, 16'h0000);
    chk("t5_start", load_start, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      chk("t5_post_we", bus_if.ram_we, 1'b0);
      tick();
    end

    // Clean load after reset, then an empty-tape completion.
    drive_tape(1'b1, 16'h0100, 8'h5A);
    sb_q.push_back({16'h0100, 8'h5A});
    tick();
    drive_tape(1'b0, 16'h0, 8'h0);
    tape_complete = 1'b1;
    #1;
    chk("t5_clean_ad", bus_if.ram_ad, 16'h0100);
    chk("t5_clean_we", bus_if.ram_we, 1'b1);
    for (int off = 0; off < 6; off++) begin
      if (off > 0) #1;
      chk("t5_clean_done", load_done, off == 2);
      tick();
    end
    chk("t5_clean_start", load_start, 16'h0100);
    chk("t5_clean_end", load_end, 16'h0100);
    chk("t5_clean_autorun", load_autorun, 1'b0);
    tape_complete = 1'b0;
    tick(); tick();

    tape_complete = 1'b1;
    tape_autorun  = 1'b1;
    for (int off = 0; off < 6; off++) begin
      #1;
      chk("t7_done", load_done, off == 2);
      if (off == 2) begin
        chk("t7_start", load_start, 16'hFFFF);
        chk("t7_end", load_end, 16'h0000);
      end
      tick();
    end
    chk("t7_autorun", load_autorun, 1'b1);
    chk("t7_sb_empty", sb_q.size(), 0);
    tape_complete = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tape_ram_writer.md
Name: tape_ram_writer

Overview:
- Downstream stage of the cassette loader. Accepts the loader's byte stream (tape_addr/tape_wr/tape_dout) and merges it into the single 64K RAM write port, which is shared with the CPU.
- CPU accesses always take priority. Tape bytes are buffered in a small FIFO and written only in cycles where the CPU does not select RAM.
- Tracks the loaded address range. Reports load completion, with the autorun flag, only after every buffered byte has reached RAM.

Parameters:
- DEPTH, 8, FIFO depth in entries (power of two, ≥4).
- AW, 16, RAM address width.

Ports:
- clk_48  in  1  system clock
- reset  in  1  synchronous, active-high
- tape_addr  in  AW  loader byte address
- tape_wr  in  1  loader byte strobe, one byte per high cycle
- tape_dout  in  8  loader byte data
- tape_complete  in  1  loader finished (level; rising edge is the event)
- tape_autorun  in  1  autorun request, sampled at the tape_complete rising edge
- cpu_ram_cs  in  1  CPU selects RAM this cycle
- cpu_ram_we  in  1  CPU write enable
- cpu_ad  in  AW  CPU address
- cpu_d  in  8  CPU write data
- ram_cs  out  1  RAM port select
- ram_we  out  1  RAM port write enable
- ram_ad  out  AW  RAM port address
- ram_d  out  8  RAM port write data
- tape_stall  out  1  back-pressure to the loader
- busy  out  1  load in progress or FIFO not empty
- overflow  out  1  sticky: a byte was dropped
- load_start  out  AW  lowest address written this load
- load_end  out  AW  highest address written this load
- load_done  out  1  one-cycle pulse when the load is fully committed
- load_autorun  out  1  autorun flag latched for this load

Behaviour:
- Reset values: all registered outputs 0, FIFO empty, state IDLE, load_start=all-ones, load_end=0. Reset mid-load discards FIFO contents. No RAM write is issued in the reset cycle.
- RAM port is a combinational mux:
  - cpu_ram_cs=1: ram_cs=1, ram_we=cpu_ram_we, ram_ad=cpu_ad, ram_d=cpu_d.
  - Else if FIFO not empty: ram_cs=1, ram_we=1, ram_ad/ram_d = FIFO head. The head is popped at this clock edge.
  - Else: ram_cs=0, ram_we=0, ram_ad=cpu_ad, ram_d=0.
- Push: tape_wr=1 pushes {tape_addr,tape_dout}. A push is accepted if count<DEPTH, or if a pop happens in the same cycle.
  - If not accepted, the byte is dropped and overflow is set. overflow clears only on reset or on the IDLE→LOADING transition.
- Simultaneous push and pop: count unchanged, both take effect.
- tape_stall is registered: 1 when the next-cycle count ≥ DEPTH-2, otherwise 0.
- Range tracking on each accepted push:
  - load_start=min(load_start,tape_addr).
  - load_end=max(load_end,tape_addr).
  - Unsigned compare, no wrap handling.
- States:
  - IDLE: first tape_wr → LOADING. Range registers reinit to the pushed address, overflow cleared.
  - LOADING: tape_complete rising edge → DRAIN, load_autorun←tape_autorun.
  - DRAIN: further pushes are still accepted. When the FIFO is empty at a clock edge with no push in that cycle → DONE.
  - DONE: load_done=1 for exactly one cycle, then → IDLE. load_start/load_end/load_autorun hold until the next load starts.
- tape_complete rising edge in IDLE (empty tape): → DRAIN directly. load_done pulses 2 cycles later with load_start=all-ones, load_end=0.
- tape_complete held high does not retrigger. Edge detection uses a registered copy, cleared by reset.
- busy=1 in LOADING/DRAIN/DONE or when count≠0.
- Latency: with the CPU idle, a tape byte presented at cycle N appears on the RAM port during cycle N+1 and is written at the end of that cycle.

Test Plan:
- CPU idle, bytes 0x11,0x22,0x33 to 0x0500..0x0502 on consecutive cycles → RAM writes appear one cycle later, in order; load_start=0x0500, load_end=0x0502.
- cpu_ram_cs=1 held for 10 cycles while 8 tape bytes arrive → ram_* follow the CPU every cycle; tape_stall=1 once count reaches 6; the FIFO holds 8; all 8 bytes write in the 8 cycles after cpu_ram_cs drops.
- CPU busy, 9 bytes pushed with no pop → 9th byte dropped, overflow=1, and RAM never sees its address.
- tape_autorun=1, tape_complete rises with 3 bytes buffered and the CPU idle → load_done pulses exactly once, 4 cycles after the edge (3 pops, then DONE); load_autorun=1; tape_complete held high gives no second pulse.
- reset asserted mid-load with 5 bytes buffered → ram_we=0 in the reset cycle and afterwards; busy=0, overflow=0, load_end=0; the subsequent load starts clean.
- Addresses pushed in order 0x9800, 0x0400, 0xBFFF → load_start=0x0400, load_end=0xBFFF.
